reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, width of the write data and of each bank register.
REQ-002 SHALL have parameter NREG, default 8, number of bank registers; AW = clog2(NREG) = 3.
REQ-003 SHALL have input clk, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have input clrn, 1 bit, synchronous active-low reset.
REQ-005 SHALL have input req, 4 bits, per-requester write request, bit i for requester i.
REQ-006 SHALL have input addr, 4*AW bits, register address of requester i in slice [i*AW +: AW].
REQ-007 SHALL have input wdata, 4*DW bits, write data of requester i in slice [i*DW +: DW].
REQ-008 SHALL have output gnt, 4 bits, registered one-hot grant pulse.
REQ-009 SHALL have output ena, NREG bits, registered one-hot enable vector to the bank's per-register enable inputs.
REQ-010 SHALL have output d, DW bits, registered data shared by all bank registers.
REQ-011 SHALL have output busy, 1 bit, high while state is WRITE.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and WRITE.
REQ-013 In IDLE with req != 0, SHALL select a winner round-robin, starting at pointer ptr (2 bits) and searching upward modulo 4; it SHALL capture the winner index, addr slice and wdata slice, then enter WRITE.
REQ-014 In IDLE with req == 0, SHALL stay in IDLE with gnt, ena and d all 0.
REQ-015 In WRITE, for exactly one cycle, SHALL drive gnt[winner]=1, ena[captured addr]=1 with all other ena bits 0, and d = captured data; it SHALL then return to IDLE.
REQ-016 Latency: req sampled high at edge N -> gnt, ena and d valid in cycle N+1; the bank captures at edge N+1.
REQ-017 Throughput: at most one write per 2 cycles.
REQ-018 On leaving WRITE, SHALL set ptr = winner+1 modulo 4.
REQ-019 Handshake: the requester SHALL hold req, addr and wdata stable until it samples gnt high, then deassert req at that edge.
REQ-020 A req still high in the IDLE cycle following its gnt SHALL be treated as a new request.
REQ-021 req changes during WRITE SHALL NOT affect the write in progress; the write uses only the values captured in IDLE.
REQ-022 A captured addr >= NREG SHALL produce ena = 0, while gnt is still pulsed.
REQ-023 When multiple requests are simultaneous, exactly one SHALL be granted per arbitration; the others wait, and no requester is skipped twice in a row.

Reset
REQ-024 When clrn = 0 at a rising edge, SHALL set state=IDLE, ptr=0, gnt=0, ena=0, d=0 and busy=0, and clear the captured registers.
REQ-025 If clrn = 0 at the edge ending a WRITE cycle, the enables already presented during that cycle SHALL stand, so the bank captures normally, and the arbiter resets.
REQ-026 A request captured in IDLE and followed by reset before WRITE SHALL be discarded with no gnt pulse; the requester must re-arbitrate.

Configuration
REQ-027 With macro REG_LOCK_EN defined, SHALL add input lock (NREG bits) and output err (1 bit, registered).
REQ-028 With REG_LOCK_EN defined, a WRITE to an address with lock[addr]=1 SHALL pulse gnt and pulse err=1 for the same cycle, with ena = 0.
REQ-029 With REG_LOCK_EN defined, lock SHALL be sampled in IDLE together with addr, and err SHALL reset to 0.
REQ-030 Without REG_LOCK_EN, the lock and err ports SHALL be absent and every write with addr < NREG SHALL proceed.

Verification
REQ-031 Single requester: req=4'b0001, addr0=3, wdata0=8'hA5 sampled at edge N -> cycle N+1 has gnt=0001, ena=8'h08, d=A5, busy=1; cycle N+2 has all outputs 0.
REQ-032 Contention: req=4'b1111 held, each requester dropping on its own gnt -> grants occur in order 0,1,2,3, spaced 2 cycles apart, with ptr=0 after the last grant.
REQ-033 Fairness: req0 and req2 both re-assert immediately after each grant for 8 arbitrations -> grants alternate 0,2,0,2 and neither is granted twice in a row.
REQ-034 Reset mid-operation: clrn=0 at the edge after capture (entering WRITE) -> the following cycle has gnt=0, ena=0, state IDLE and ptr=0.
REQ-035 Out of range: NREG=6 with addr=7 -> gnt pulsed and ena=0.
REQ-036 Lock (REG_LOCK_EN defined): lock=8'h04 and a write to addr 2 -> gnt pulsed, err=1, ena=0; a write to addr 3 -> ena=8'h08, err=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Four-requester round-robin arbiter that funnels register writes into a
// bank: one registered grant / one-hot enable / data beat per two cycles.
//
// Ports:
//   clk    rising-edge clock
//   clrn   synchronous active-low reset
//   req    per-requester write request (bit i = requester i)
//   addr   register address of requester i at [i*AW +: AW]
//   wdata  write data of requester i at [i*DW +: DW]
//   gnt    registered one-hot grant pulse
//   ena    registered one-hot per-register enable (0 if addr >= NREG)
//   d      registered write data shared by all bank registers
//   busy   high while the WRITE beat is presented
// Optional build macro REG_LOCK_EN adds:
//   lock   per-register write lock, sampled with addr during arbitration
//   err    registered pulse, set when the granted write hits a locked register
module reg_write_arbiter #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [3:0]      req,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
`ifdef REG_LOCK_EN
  input  logic [NREG-1:0] lock,
  output logic            err,
`endif
  output logic [3:0]      gnt,
  output logic [NREG-1:0] ena,
  output logic [DW-1:0]   d,
  output logic            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [1:0]      ptr, ptr_n;
  logic [1:0]      win_q, win_n;
  logic [3:0]      gnt_n;
  logic [NREG-1:0] ena_n;
  logic [DW-1:0]   d_n;

  logic [1:0]      sel, idx;
  logic            found;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            in_rng;
  logic            locked;

`ifdef REG_LOCK_EN
  logic            err_n;
`endif

  // First requesting index at or above ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_addr = addr[sel*AW +: AW];
  assign sel_data = wdata[sel*DW +: DW];
  assign in_rng   = int'(sel_addr) < NREG;

`ifdef REG_LOCK_EN
  assign locked = in_rng && lock[sel_addr];
`else
  assign locked = 1'b0;
`endif

  // The beat is registered on the arbitration edge, so the output
  // registers themselves hold the captured address decode and data.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win_q;
    gnt_n   = '0;
    ena_n   = '0;
    d_n     = '0;
`ifdef REG_LOCK_EN
    err_n   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = WRITE;
          win_n   = sel;
          gnt_n   = 4'b0001 << sel;
          d_n     = sel_data;
          if (in_rng && !locked)
            ena_n = {{(NREG-1){1'b0}}, 1'b1} << sel_addr;
`ifdef REG_LOCK_EN
          err_n   = locked;
`endif
        end
      end
      WRITE: begin
        state_n = IDLE;
        ptr_n   = win_q + 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Reset also wins over the arbitration edge, so a request seen
  // together with clrn=0 never produces a grant.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state <= IDLE;
      ptr   <= '0;
      win_q <= '0;
      gnt   <= '0;
      ena   <= '0;
      d     <= '0;
`ifdef REG_LOCK_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      win_q <= win_n;
      gnt   <= gnt_n;
      ena   <= ena_n;
      d     <= d_n;
`ifdef REG_LOCK_EN
      err   <= err_n;
`endif
    end
  end

  assign busy = (state == WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized + directed bench for reg_write_arbiter against a
// cycle-level reference model of the arbitration rules.
module tb_reg_write_arbiter;

  localparam int DW = 8;
  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        clrn;
  logic [3:0]  req;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  ena;
  logic [7:0]  d;
  logic        busy;

  logic [3:0]  r6;
  logic [11:0] a6;
  logic [31:0] w6;
  logic [3:0]  g6;
  logic [5:0]  e6;
  logic [7:0]  d6;
  logic        b6;

`ifdef REG_LOCK_EN
  logic [7:0]  lock;
  logic        err;
  logic [5:0]  lock6;
  logic        err6;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int mptr  = 0;
  int mwin  = 0;
  bit mbusy = 1'b0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DW(DW), .NREG(NR)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .req   (req),
    .addr  (addr),
    .wdata (wdata),
`ifdef REG_LOCK_EN
    .lock  (lock),
    .err   (err),
`endif
    .gnt   (gnt),
    .ena   (ena),
    .d     (d),
    .busy  (busy)
  );

  reg_write_arbiter #(.DW(DW), .NREG(6)) dut6 (
    .clk   (clk),
    .clrn  (clrn),
    .req   (r6),
    .addr  (a6),
    .wdata (w6),
`ifdef REG_LOCK_EN
    .lock  (lock6),
    .err   (err6),
`endif
    .gnt   (g6),
    .ena   (e6),
    .d     (d6),
    .busy  (b6)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Predict the post-edge outputs from the inputs present at the edge,
  // then advance one clock and compare.
  task automatic tick();
    logic [3:0] eg;
    logic [7:0] ee;
    logic [7:0] ed;
    logic       eerr;
    int         a;
    eg = '0; ee = '0; ed = '0; eerr = 1'b0;
    if (!clrn) begin
      mbusy = 1'b0;
      mptr  = 0;
    end else if (mbusy) begin
      mbusy = 1'b0;
      mptr  = (mwin + 1) % 4;
    end else if (req != 0) begin
      for (int k = 0; k < 4; k++) begin
        if (req[(mptr + k) % 4]) begin
          mwin = (mptr + k) % 4;
          break;
        end
      end
      a     = int'(addr[mwin*3 +: 3]);
      eg    = 4'(1 << mwin);
      ed    = wdata[mwin*8 +: 8];
      ee    = (a < NR) ? 8'(1 << a) : 8'h00;
`ifdef REG_LOCK_EN
      if (a < NR && lock[a]) begin
        ee   = 8'h00;
        eerr = 1'b1;
      end
`endif
      mbusy = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt",  32'(gnt),  32'(eg));
    chk("ena",  32'(ena),  32'(ee));
    chk("d",    32'(d),    32'(ed));
    chk("busy", 32'(busy), 32'(mbusy));
`ifdef REG_LOCK_EN
    chk("err",  32'(err),  32'(eerr));
`else
    eerr = eerr;
`endif
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
  endtask

  task automatic new_req(input int i);
    req[i]          = 1'b1;
    addr[i*3 +: 3]  = 3'($urandom);
    wdata[i*8 +: 8] = 8'($urandom);
  endtask

  int gw[16];
  int gc[16];
  int n;

  initial begin
    clrn = 1'b0; req = '0; addr = '0; wdata = '0;
    r6 = '0; a6 = '0; w6 = '0;
`ifdef REG_LOCK_EN
    lock = '0; lock6 = '0;
`endif
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ena", 32'(ena), 0);
    clrn = 1'b1;
    tick();

    // Single requester
    req = 4'b0001; addr[2:0] = 3'd3; wdata[7:0] = 8'hA5;
    tick();
    chk("s_gnt",  32'(gnt),  32'h1);
    chk("s_ena",  32'(ena),  32'h08);
    chk("s_d",    32'(d),    32'hA5);
    chk("s_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    chk("s_gnt0", 32'(gnt), 0);
    chk("s_d0",   32'(d),   0);

    // Full contention, each drops on its own grant
    do_reset();
    for (int i = 0; i < 4; i++) new_req(i);
    n = 0;
    for (int c = 0; c < 20 && req != 0; c++) begin
      tick();
      if (gnt != 0 && n < 16) begin
        gw[n] = $clog2(gnt);
        gc[n] = cyc;
        n++;
        req = req & ~gnt;
      end
    end
    chk("c_cnt", 32'(n), 4);
    for (int k = 0; k < 4; k++) begin
      chk("c_ord", 32'(gw[k]), 32'(k));
      if (k > 0) chk("c_gap", 32'(gc[k] - gc[k-1]), 2);
    end
    req = 4'b1111;
    tick();
    tick();
    chk("c_ptr0", 32'(gnt), 32'h1);
    req = '0;
    tick();

    // Fairness between two persistent requesters
    do_reset();
    new_req(0); new_req(2);
    n = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (gnt != 0 && n < 16) begin
        gw[n] = $clog2(gnt);
        n++;
        new_req($clog2(gnt));
      end
    end
    chk("f_cnt", 32'(n), 8);
    for (int k = 0; k < 8; k++) begin
      chk("f_alt", 32'(gw[k]), (k % 2) ? 2 : 0);
    end
    req = '0;
    tick();

    // Reset on the arbitration edge discards the request
    req = 4'b0010;
    clrn = 1'b0;
    tick();
    chk("r_nognt", 32'(gnt),  0);
    chk("r_idle",  32'(busy), 0);
    clrn = 1'b1; req = '0;
    tick();

    // Reset on the edge ending WRITE: arbiter back to IDLE, ptr 0
    req = 4'b0010; addr[5:3] = 3'd6;
    tick();
    chk("r_wgnt", 32'(gnt), 32'h2);
    chk("r_wena", 32'(ena), 32'h40);
    clrn = 1'b0; req = '0;
    tick();
    chk("r_gnt0", 32'(gnt),  0);
    chk("r_ena0", 32'(ena),  0);
    chk("r_bsy0", 32'(busy), 0);
    clrn = 1'b1; req = 4'b1111;
    tick();
    chk("r_ptr0", 32'(gnt), 32'h1);
    req = '0;
    tick();

`ifdef REG_LOCK_EN
    lock = 8'h04;
    req = 4'b0001; addr[2:0] = 3'd2;
    tick();
    chk("l_gnt", 32'(gnt), 32'h1);
    chk("l_err", 32'(err), 32'h1);
    chk("l_ena", 32'(ena), 0);
    req = '0;
    tick();
    req = 4'b0001; addr[2:0] = 3'd3;
    tick();
    chk("l_ena3", 32'(ena), 32'h08);
    chk("l_err3", 32'(err), 0);
    req = '0; lock = '0;
    tick();
`endif

    // Out-of-range address on a 6-register bank
    r6 = 4'b0001; a6[2:0] = 3'd7; w6[7:0] = 8'h3C;
    tick();
    chk("o_gnt", 32'(g6), 32'h1);
    chk("o_ena", 32'(e6), 0);
    chk("o_d",   32'(d6), 32'h3C);
    r6 = '0;
    tick();
    r6 = 4'b0001; a6[2:0] = 3'd5;
    tick();
    chk("o_ena5", 32'(e6), 32'h20);
    r6 = '0;
    tick();

    // Random traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      clrn = ($urandom_range(39, 0) != 0);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(1, 0) != 0) new_req(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          new_req(i);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
